// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state encoding and step-counter sizing for
// the serial adder. Optional feature macro used by this slice:
// SERIAL_ADDER_SUB_EN (adds the sub port and a - b support).
package serial_adder_pkg;

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // RUN   | adding one digit per clock, LSB digit first
  // DONE  | result presented, waiting for out_ready
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter must hold the value STEPS, hence STEPS+1 codes.
  function automatic int step_cnt_width(input int steps);
    return (steps < 1) ? 1 : $clog2(steps + 1);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand and result handshakes of the serial adder.
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Producer of operands / consumer of results.
  modport master (
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // The adder itself.
  modport slave (
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/serial_adder_digit_adder.sv
// digit_adder: combinational ripple of DIGIT full-adder cells, each cell made
// of two half adders and an OR. c_top is the carry into the top bit of the
// digit, which on the final step is the carry into the word MSB.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_top
);

  // Ripple the carry through the cells, remembering the carry into the top cell.
  always_comb begin : ripple
    logic cc;
    logic hs;
    cc    = ci;
    hs    = 1'b0;
    s     = '0;
    c_top = ci;
    for (int i = 0; i < DIGIT; i++) begin
      c_top = cc;
      hs    = a[i] ^ b[i];
      s[i]  = hs ^ cc;
      cc    = (a[i] & b[i]) | (hs & cc);
    end
    co = cc;
  end

endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder, DIGIT bits per clock, LSB digit first.
// Result (sum, cout, signed ovf) appears WIDTH/DIGIT cycles after the
// accepting edge. Define SERIAL_ADDER_SUB_EN to add the sub port (a - b).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_adder_if.slave bus
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = step_cnt_width(STEPS);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] count;

  logic [DIGIT-1:0]       dig_sum;
  logic                   dig_co;
  logic                   dig_ctop;
  logic [WIDTH+DIGIT-1:0] sum_cat;
  logic [WIDTH-1:0]       sum_next;
  logic                   last_step;
  logic [WIDTH-1:0]       b_load;
  logic                   carry_load;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a     (a_sr[DIGIT-1:0]),
    .b     (b_sr[DIGIT-1:0]),
    .ci    (carry),
    .s     (dig_sum),
    .co    (dig_co),
    .c_top (dig_ctop)
  );

  // New digit enters at the MSB end; after STEPS shifts the word is aligned.
  assign sum_cat   = {dig_sum, sum_sr};
  assign sum_next  = sum_cat[WIDTH+DIGIT-1:DIGIT];
  assign last_step = (count == CNT_W'(STEPS - 1));

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction as a + ~b + 1; cin is ignored when sub is set.
  assign b_load     = bus.sub ? ~bus.b : bus.b;
  assign carry_load = bus.sub | bus.cin;
`else
  assign b_load     = bus.b;
  assign carry_load = bus.cin;
`endif

  // Sequencer: accept, shift-add STEPS digits, hold result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      a_sr        <= '0;
      b_sr        <= '0;
      sum_sr      <= '0;
      sum_q       <= '0;
      carry       <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_sr       <= bus.a;
            b_sr       <= b_load;
            carry      <= carry_load;
            sum_sr     <= '0;
            count      <= '0;
            in_ready_q <= 1'b0;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          sum_sr <= sum_next;
          carry  <= dig_co;
          count  <= count + CNT_W'(1);
          if (last_step) begin
            sum_q       <= sum_next;
            cout_q      <= dig_co;
            ovf_q       <= dig_ctop ^ dig_co;
            out_valid_q <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder at W8/D1, W16/D4 and an
// exhaustive W4/D2 sweep. Subtraction vectors run when SERIAL_ADDER_SUB_EN
// is defined.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_err = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8))  bus8 ();
  serial_adder_if #(.WIDTH(16)) bus16 ();
  serial_adder_if #(.WIDTH(4))  bus4 ();

  serial_adder #(.WIDTH(8),  .DIGIT(1)) u_w8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder #(.WIDTH(16), .DIGIT(4)) u_w16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  serial_adder #(.WIDTH(4),  .DIGIT(2)) u_w4  (.clk(clk), .rst_n(rst_n), .bus(bus4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.cin = c; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
  endtask

  task automatic wait8(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus8.out_valid && lat < 40);
  endtask

  task automatic take8();
    @(negedge clk);
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [7:0] es, input logic eco, input logic eov);
    int lat;
    start8(a, b, c);
    wait8(lat);
    chk({tag, " latency"}, lat, 8);
    chk({tag, " sum"}, bus8.sum, es);
    chk({tag, " cout"}, bus8.cout, eco);
    chk({tag, " ovf"}, bus8.ovf, eov);
    take8();
  endtask

  task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic [15:0] es, input logic eco, input logic eov);
    int lat;
    @(negedge clk);
    bus16.a = a; bus16.b = b; bus16.cin = c; bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus16.out_valid && lat < 40);
    chk({tag, " latency"}, lat, 4);
    chk({tag, " sum"}, bus16.sum, es);
    chk({tag, " cout"}, bus16.cout, eco);
    chk({tag, " ovf"}, bus16.ovf, eov);
    @(negedge clk);
    bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus16.out_ready = 1'b0;
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [4:0] full;
    logic [5:0] exp_v;
    int         lat;
    full  = {1'b0, a} + {1'b0, b} + {4'd0, c};
    exp_v = {full[4], (a[3] == b[3]) && (full[3] != a[3]), full[3:0]};
    @(negedge clk);
    bus4.a = a; bus4.b = b; bus4.cin = c; bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus4.out_valid && lat < 20);
    chk($sformatf("w4 a=%0h b=%0h c=%0d lat", a, b, c), lat, 2);
    chk($sformatf("w4 a=%0h b=%0h c=%0d {cout,ovf,sum}", a, b, c),
        {bus4.cout, bus4.ovf, bus4.sum}, exp_v);
    @(negedge clk);
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
  endtask

  initial begin
    bus8.in_valid = 0;  bus8.a = 0;  bus8.b = 0;  bus8.cin = 0;  bus8.out_ready = 0;
    bus16.in_valid = 0; bus16.a = 0; bus16.b = 0; bus16.cin = 0; bus16.out_ready = 0;
    bus4.in_valid = 0;  bus4.a = 0;  bus4.b = 0;  bus4.cin = 0;  bus4.out_ready = 0;
`ifdef SERIAL_ADDER_SUB_EN
    bus8.sub = 0; bus16.sub = 0; bus4.sub = 0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", bus8.out_valid, 0);
    chk("reset sum", bus8.sum, 0);
    chk("reset cout/ovf", {bus8.cout, bus8.ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset in_ready", bus8.in_ready, 1);

    // Basic additions
    op8("3c+55", 8'h3C, 8'h55, 1'b0, 8'h91, 1'b0, 1'b1);
    op8("ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("00+00+1", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);

    // Backpressure in DONE with ignored in_valid pulses
    begin
      int lat;
      start8(8'h3C, 8'h55, 1'b0);
      chk("bp in_ready in RUN", bus8.in_ready, 0);
      wait8(lat);
      chk("bp latency", lat, 8);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        bus8.in_valid = (i % 2 == 0);
        bus8.a = 8'hAA; bus8.b = 8'h11;
        @(posedge clk); #1;
        chk($sformatf("bp%0d out_valid", i), bus8.out_valid, 1);
        chk($sformatf("bp%0d sum", i), bus8.sum, 8'h91);
        chk($sformatf("bp%0d cout/ovf", i), {bus8.cout, bus8.ovf}, 2'b01);
        chk($sformatf("bp%0d in_ready", i), bus8.in_ready, 0);
      end
      @(negedge clk);
      bus8.in_valid = 1'b0;
      bus8.out_ready = 1'b1;
      @(posedge clk); #1;
      bus8.out_ready = 1'b0;
      chk("bp release in_ready", bus8.in_ready, 1);
      chk("bp release out_valid", bus8.out_valid, 0);
      @(posedge clk); #1;
      chk("bp nothing queued", bus8.out_valid, 0);
    end

    // Reset in the middle of RUN
    start8(8'h3C, 8'h55, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", bus8.out_valid, 0);
    chk("abort sum", bus8.sum, 0);
    chk("abort cout/ovf", {bus8.cout, bus8.ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort in_ready after release", bus8.in_ready, 1);
    repeat (9) @(posedge clk);
    #1;
    chk("abort no stale result", bus8.out_valid, 0);
    op8("12+34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

    // Wider digits
    op16("7fff+1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    op16("ffff+1+1", 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0);

    // Exhaustive W4 D2
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          op4(4'(a), 4'(b), 1'(c));

`ifdef SERIAL_ADDER_SUB_EN
    bus8.sub = 1'b1;
    op8("05-07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    op8("80-01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
    bus8.sub = 1'b0;
    op8("05+07", 8'h05, 8'h07, 1'b0, 8'h0C, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
